// File: rtl/aldff_load_pkg.sv
// Shared types and constants for the ALDFF async-load sequencer.
package aldff_load_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int HOLD_MAX = 255;

  function automatic int cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/aldff_hold_cnt.sv
// Loadable down-counter for the L-high phase; saturates at zero.
module aldff_hold_cnt #(
  parameter int W = 2
) (
  input  logic         C,
  input  logic         R,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge C) begin
    if (R)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/aldff_load_seq.sv
// Sequencer for the C/L/AD/E pins of an ALDFF register bank.
// Optional readback compare of Q against AD: define ALDFF_LOAD_CHECK_EN.
//
//   state   | meaning
//   IDLE    | E follows run_en, waiting for a load request
//   SETUP   | AD presented, L low, E gated
//   LOAD    | L high for HOLD cycles
//   RELEASE | L low again; done and return to IDLE next edge
module aldff_load_seq
  import aldff_load_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int HOLD  = 2
) (
  input  logic             C,
  input  logic             R,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_ad,
  input  logic             run_en,
  output logic             L,
  output logic [WIDTH-1:0] AD,
  output logic             E,
  output logic             busy,
  output logic             done
`ifdef ALDFF_LOAD_CHECK_EN
  ,
  input  logic [WIDTH-1:0] Q,
  output logic             mismatch
`endif
);

  localparam int CW = cnt_width(HOLD);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);

  generate
    if (HOLD < 1 || HOLD > HOLD_MAX) begin : g_bad_hold
      $error("aldff_load_seq: HOLD out of range 1..255");
    end
  endgenerate

  state_t state;
  logic   cnt_zero;
  logic   accept;

  assign req_ready = (state == IDLE) && !R;
  assign accept    = req_valid && req_ready;

  aldff_hold_cnt #(.W(CW)) u_hold_cnt (
    .C        (C),
    .R        (R),
    .load     (state == SETUP),
    .dec      (state == LOAD),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state <= IDLE;
      L     <= 1'b0;
      AD    <= '0;
      E     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          E <= run_en;
          if (accept) begin
            AD    <= req_ad;
            E     <= 1'b0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          L     <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          if (cnt_zero) begin
            L     <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALDFF_LOAD_CHECK_EN
  // Sticky until the next accept so software can read it after done.
  always_ff @(posedge C) begin
    if (R)
      mismatch <= 1'b0;
    else if (accept)
      mismatch <= 1'b0;
    else if ((state == RELEASE) && (Q != AD))
      mismatch <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_aldff_load_seq.sv
// Directed bench for aldff_load_seq: HOLD=2 main instance plus a HOLD=1 instance.
module tb_aldff_load_seq;

  logic       C = 1'b0;
  logic       R;
  logic       req_valid, run_en;
  logic [6:0] req_ad;
  logic       req_ready, L, E, busy, done;
  logic [6:0] AD;

  logic       v1, run_en1;
  logic [6:0] ad1;
  logic       ready1, L1, E1, busy1, done1;
  logic [6:0] AD1;

`ifdef ALDFF_LOAD_CHECK_EN
  logic       q_force;
  logic [6:0] q_val;
  logic [6:0] Q;
  logic       mismatch, mismatch1;
  assign Q = q_force ? q_val : AD;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 C = ~C;

  aldff_load_seq #(.WIDTH(7), .HOLD(2)) dut (
    .C(C), .R(R), .req_valid(req_valid), .req_ready(req_ready), .req_ad(req_ad),
    .run_en(run_en), .L(L), .AD(AD), .E(E), .busy(busy), .done(done)
`ifdef ALDFF_LOAD_CHECK_EN
    , .Q(Q), .mismatch(mismatch)
`endif
  );

  aldff_load_seq #(.WIDTH(7), .HOLD(1)) dut1 (
    .C(C), .R(R), .req_valid(v1), .req_ready(ready1), .req_ad(ad1),
    .run_en(run_en1), .L(L1), .AD(AD1), .E(E1), .busy(busy1), .done(done1)
`ifdef ALDFF_LOAD_CHECK_EN
    , .Q(AD1), .mismatch(mismatch1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  int acc[4];
  int n_acc;
  int lcount;

  initial begin
    R = 1'b1; req_valid = 1'b1; run_en = 1'b1; req_ad = 7'h33;
    v1 = 1'b0; run_en1 = 1'b0; ad1 = 7'h0F;
`ifdef ALDFF_LOAD_CHECK_EN
    q_force = 1'b0; q_val = 7'h00;
`endif
    // reset held with request pending
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_L", L, 0);
      check("rst_AD", AD, 0);
      check("rst_E", E, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", req_ready, 0);
    end
    R = 1'b0; req_valid = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);
    step();
    check("idle_E", E, 1);

    // basic load 7'h55
    req_valid = 1'b1; req_ad = 7'h55;
    step();                       // edge 0
    req_valid = 1'b0;
    check("setup_AD", AD, 7'h55);
    check("setup_L", L, 0);
    check("setup_E", E, 0);
    check("setup_busy", busy, 1);
    step();                       // edge 1
    check("load1_L", L, 1);
    step();                       // edge 2
    check("load2_L", L, 1);
    check("load2_done", done, 0);
    step();                       // edge 3
    check("rel_L", L, 0);
    check("rel_done", done, 0);
    check("rel_busy", busy, 1);
    step();                       // edge 4
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_ready", req_ready, 1);
    check("done_E", E, 0);
    step();                       // edge 5
    check("post_done", done, 0);
    check("post_E", E, 1);
    check("hold_AD", AD, 7'h55);

    // backpressure: second request held while busy
    req_valid = 1'b1; req_ad = 7'h55;
    step();                       // edge 0
    req_ad = 7'h2A;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("bp_AD_held", AD, 7'h55);
      check("bp_busy", busy, 1);
    end
    step();                       // edge 4
    check("bp_done", done, 1);
    check("bp_ready", req_ready, 1);
    check("bp_AD_done", AD, 7'h55);
    step();                       // edge 5 accept
    req_valid = 1'b0;
    check("bp_AD_new", AD, 7'h2A);
    check("bp_busy2", busy, 1);
    check("bp_done_clr", done, 0);
    for (int i = 0; i < 4; i++) step();
    check("bp_done2", done, 1);
    step();

    // reset during first L-high cycle
    req_valid = 1'b1; req_ad = 7'h11;
    step();
    req_valid = 1'b0;
    step();
    check("mid_L_high", L, 1);
    R = 1'b1;
    #1;
    check("mid_ready_rst", req_ready, 0);
    step();
    check("mid_L", L, 0);
    check("mid_AD", AD, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    R = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_no_done", done, 0);
    end
    check("mid_E_back", E, 1);

`ifdef ALDFF_LOAD_CHECK_EN
    // readback compare
    q_force = 1'b1; q_val = 7'h54;
    req_valid = 1'b1; req_ad = 7'h55;
    step();
    req_valid = 1'b0;
    step(); step(); step();       // in RELEASE
    check("mm_before", mismatch, 0);
    step();
    check("mm_set", mismatch, 1);
    step();
    check("mm_sticky", mismatch, 1);
    q_force = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("mm_clr_accept", mismatch, 0);
    for (int i = 0; i < 5; i++) step();
    check("mm_good", mismatch, 0);
`endif

    // HOLD=1 instance, request held continuously
    n_acc = 0; lcount = 0;
    v1 = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (ready1 && v1 && n_acc < 4) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      step();
      if (L1) lcount++;
    end
    v1 = 1'b0;
    check("h1_accepts", n_acc, 3);
    check("h1_period_a", acc[1] - acc[0], 4);
    check("h1_period_b", acc[2] - acc[1], 4);
    check("h1_L_cycles", lcount, 3);
    check("h1_AD", AD1, 7'h0F);
`ifdef ALDFF_LOAD_CHECK_EN
    check("h1_mismatch", mismatch1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
